// File: rtl/dds_dac_pkg.sv
// Shared types and constants for the DDS-to-DAC SPI transmitter.
package dds_dac_pkg;

  localparam int FRAME_BITS = 8 + 16;
  localparam logic [7:0] DEFAULT_CMD_WORD = 8'h30;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CS_HOLD = 3'd3,
    ST_LATCH   = 3'd4
  } state_t;

endpackage

// File: rtl/dds_dac_sclk_gen.sv
// Half-period tick generator for SCLK: one tick every CLK_DIV enabled cycles,
// alternating rise/fall. Disabling it parks the phase low with a fresh count.
module dds_dac_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       phase;
  logic       wrap;

  assign wrap      = en && (cnt == LAST);
  assign rise_tick = wrap && !phase;
  assign fall_tick = wrap && phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dds_dac_spi_tx.sv
// Serialises DDS samples as 24-bit SPI frames (command + data) to a 16-bit DAC.
// Define DDS_DAC_OFFSET_BIN_EN to send offset-binary instead of two's complement.
module dds_dac_spi_tx
  import dds_dac_pkg::*;
#(
  parameter int         CLK_DIV        = 2,
  parameter logic [7:0] CMD_WORD       = DEFAULT_CMD_WORD,
  parameter int         CS_IDLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  input  logic [15:0]           sample_data,
  output logic                  sample_ready,
  output logic                  dac_sclk,
  output logic                  dac_cs_n,
  output logic                  dac_mosi,
  output logic                  dac_ldac_n,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [4:0] LAST_BIT  = 5'(FRAME_BITS - 1);
  localparam logic [3:0] LAST_HOLD = 4'(CS_IDLE_CYCLES - 1);

  state_t                  state, state_next;
  logic [FRAME_BITS-1:0]   shift_reg, shift_next;
  logic [4:0]              bit_cnt, bit_next;
  logic [3:0]              hold_cnt, hold_next;
  logic                    sclk_next, mosi_next;
  logic                    gen_en, rise_tick, fall_tick;
  logic [15:0]             captured;

`ifdef DDS_DAC_OFFSET_BIN_EN
  assign captured = {~sample_data[15], sample_data[14:0]};
`else
  assign captured = sample_data;
`endif

  assign gen_en = (state == ST_SETUP) || (state == ST_SHIFT);

  dds_dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (gen_en),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    bit_next   = bit_cnt;
    hold_next  = hold_cnt;
    sclk_next  = dac_sclk;
    mosi_next  = dac_mosi;
    case (state)
      ST_IDLE: begin
        if (sample_valid && sample_ready) begin
          state_next = ST_SETUP;
          shift_next = {CMD_WORD, captured};
          bit_next   = '0;
          sclk_next  = 1'b0;
          mosi_next  = CMD_WORD[7];
        end
      end
      ST_SETUP: begin
        if (rise_tick) begin
          state_next = ST_SHIFT;
          sclk_next  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (rise_tick) begin
          sclk_next = 1'b1;
        end else if (fall_tick) begin
          sclk_next = 1'b0;
          // The 24th falling edge closes the frame instead of shifting again.
          if (bit_cnt == LAST_BIT) begin
            state_next = ST_CS_HOLD;
            mosi_next  = 1'b0;
            hold_next  = '0;
          end else begin
            shift_next = shift_reg << 1;
            mosi_next  = shift_reg[FRAME_BITS-2];
            bit_next   = bit_cnt + 5'd1;
          end
        end
      end
      ST_CS_HOLD: begin
        mosi_next = 1'b0;
        if (hold_cnt == LAST_HOLD) state_next = ST_LATCH;
        else                       hold_next  = hold_cnt + 4'd1;
      end
      ST_LATCH: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change together with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      hold_cnt     <= '0;
      dac_sclk     <= 1'b0;
      dac_cs_n     <= 1'b1;
      dac_mosi     <= 1'b0;
      dac_ldac_n   <= 1'b1;
      busy         <= 1'b0;
      sample_ready <= 1'b1;
      drop_cnt     <= '0;
    end else begin
      state        <= state_next;
      shift_reg    <= shift_next;
      bit_cnt      <= bit_next;
      hold_cnt     <= hold_next;
      dac_sclk     <= sclk_next;
      dac_mosi     <= mosi_next;
      dac_cs_n     <= !((state_next == ST_SETUP) || (state_next == ST_SHIFT));
      dac_ldac_n   <= (state_next != ST_LATCH);
      busy         <= (state_next != ST_IDLE);
      sample_ready <= (state_next == ST_IDLE);
      if (sample_valid && !sample_ready && (drop_cnt != '1))
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

endmodule
